// File: rtl/rx_cc_pkg.sv
// Shared types and constants for the RX clock-compensation read side.
// FIFO word layout: SOF mark above a 32-bit data word.
package rx_cc_pkg;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;

  localparam int SOF_BIT  = 32;
  localparam int DATA_W   = 32;
  localparam int RS_N_DEF = 255;
  localparam int RS_K_DEF = 223;
endpackage

// File: rtl/rx_cc_sym_cnt.sv
// RS block symbol counter with wrap, SOF resync-load and data/check decode.
// Index and tags are combinational on the current head word; the count updates on pop.
module rx_cc_sym_cnt
  import rx_cc_pkg::*;
#(
  parameter int RS_N     = RS_N_DEF,
  parameter int RS_K     = RS_K_DEF,
  parameter int RS_CNT_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pop_i,
  input  logic                sof_i,
  output logic [RS_CNT_W-1:0] idx_o,
  output logic                data_sym_o,
  output logic                check_sym_o,
  output logic                resync_o,
  output logic                blk_end_o
);
  localparam logic [RS_CNT_W-1:0] LAST_IDX = RS_CNT_W'(RS_N - 1);
  localparam logic [RS_CNT_W-1:0] K_LIM    = RS_CNT_W'(RS_K);

  logic [RS_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // An SOF seen mid-block restarts the block on this very word.
    idx_o       = (sof_i && (cnt_q != '0)) ? '0 : cnt_q;
    resync_o    = pop_i && sof_i && (cnt_q != '0);
    blk_end_o   = pop_i && (idx_o == LAST_IDX);
    data_sym_o  = (idx_o < K_LIM);
    check_sym_o = ~data_sym_o;
    cnt_d       = cnt_q;
    if (pop_i) begin
      cnt_d = blk_end_o ? '0 : idx_o + RS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_cc_rd_ctrl.sv
// Read sequencer for the RX CC FIFO: waits for half-full, then drains whole RS blocks.
// Pop is combinational on !empty; tagged output word is registered one cycle after the pop.
module rx_cc_rd_ctrl
  import rx_cc_pkg::*;
#(
  parameter int ADD_WIDTH = 4,
  parameter int RS_N      = RS_N_DEF,
  parameter int RS_K      = RS_K_DEF,
  parameter int RS_CNT_W  = 10
) (
  input  logic                 i_core_clk,
  input  logic                 i_core_rst,
  input  logic                 i_r_enable,
  input  logic [ADD_WIDTH-1:0] i_r_half_thres,
  input  logic [32:0]          i_c_fifo_rdata,
  input  logic                 i_c_fifo_empty,
  input  logic [ADD_WIDTH:0]   i_c_fifo_level,
  output logic                 o_c_fifo_rd_en,
  output logic [31:0]          o_c_data,
  output logic                 o_c_data_valid,
  output logic                 o_c_sof,
  output logic                 o_c_rs_data_symbol,
  output logic                 o_c_rs_check_symbol,
  output logic                 o_c_underflow,
  output logic [7:0]           o_c_resync_cnt
);
  state_e                state_q, state_d;
  logic [ADD_WIDTH-1:0]  thr;
  logic                  ready;
  logic                  pop;
  logic [RS_CNT_W-1:0]   idx;
  logic                  data_sym, check_sym, resync, blk_end;

  logic [DATA_W-1:0]     data_q;
  logic                  vld_q, sof_q, dsym_q, csym_q, unf_q;
  logic [7:0]            rcnt_q;

  assign thr   = (i_r_half_thres == '0) ? ADD_WIDTH'(1) : i_r_half_thres;
  assign ready = (i_c_fifo_level >= {1'b0, thr});

  rx_cc_sym_cnt #(
    .RS_N     (RS_N),
    .RS_K     (RS_K),
    .RS_CNT_W (RS_CNT_W)
  ) u_sym_cnt (
    .clk_i       (i_core_clk),
    .rst_i       (i_core_rst),
    .pop_i       (pop),
    .sof_i       (i_c_fifo_rdata[SOF_BIT]),
    .idx_o       (idx),
    .data_sym_o  (data_sym),
    .check_sym_o (check_sym),
    .resync_o    (resync),
    .blk_end_o   (blk_end)
  );

  always_ff @(posedge i_core_clk) begin
    if (i_core_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_r_enable) state_d = FILL;
      FILL: begin
        if (!i_r_enable) state_d = IDLE;
        else if (ready)  state_d = STREAM;
      end
      STREAM: begin
        // Enable is only honoured at a block boundary.
        if (blk_end) begin
          if (i_r_enable && ready) state_d = STREAM;
          else if (i_r_enable)     state_d = FILL;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = (state_q == STREAM) && !i_c_fifo_empty && !i_core_rst;
  end

  always_ff @(posedge i_core_clk) begin
    if (i_core_rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      sof_q  <= 1'b0;
      dsym_q <= 1'b0;
      csym_q <= 1'b0;
      unf_q  <= 1'b0;
      rcnt_q <= '0;
    end else begin
      vld_q  <= pop;
      sof_q  <= pop && (idx == '0) && i_c_fifo_rdata[SOF_BIT];
      dsym_q <= pop && data_sym;
      csym_q <= pop && check_sym;
      if (pop) data_q <= i_c_fifo_rdata[DATA_W-1:0];
      if ((state_q == STREAM) && i_c_fifo_empty) unf_q <= 1'b1;
      if (resync && (rcnt_q != 8'hFF)) rcnt_q <= rcnt_q + 8'd1;
    end
  end

  assign o_c_fifo_rd_en      = pop;
  assign o_c_data            = data_q;
  assign o_c_data_valid      = vld_q;
  assign o_c_sof             = sof_q;
  assign o_c_rs_data_symbol  = dsym_q;
  assign o_c_rs_check_symbol = csym_q;
  assign o_c_underflow       = unf_q;
  assign o_c_resync_cnt      = rcnt_q;
endmodule

// File: doc/rx_cc_rd_ctrl.md
Name: rx_cc_rd_ctrl

Overview:
Read-side sequencer for the RX clock-compensation async FIFO, in the core clock domain.
- Holds off reading until the FIFO level reaches the half-full threshold.
- Then drains whole RS blocks, tagging each word as RS data or RS check symbol.
- Resynchronises the block counter whenever a start-of-frame (SOF) marked word appears mid-block.
- Feeds the downstream RS decoder.

Parameters:
ADD_WIDTH, 4, FIFO address width; the level input is ADD_WIDTH+1 bits wide.
RS_N, 255, RS codeword length in 32-bit words.
RS_K, 223, RS data words per codeword; must satisfy RS_K < RS_N.
RS_CNT_W, 10, width of the block symbol counter; must satisfy 2^RS_CNT_W > RS_N.

Ports:
i_core_clk  input  1  core clock; all logic on its rising edge.
i_core_rst  input  1  synchronous, active-high reset.
i_r_enable  input  1  run enable.
i_r_half_thres  input  ADD_WIDTH  start/continue threshold in words; a value of 0 is treated as 1.
i_c_fifo_rdata  input  33  FIFO head word, first-word-fall-through: bit 32 = SOF mark, bits 31:0 = data.
i_c_fifo_empty  input  1  FIFO empty.
i_c_fifo_level  input  ADD_WIDTH+1  FIFO occupancy in core-domain words.
o_c_fifo_rd_en  output  1  pop strobe (combinational).
o_c_data  output  32  output word (registered).
o_c_data_valid  output  1  o_c_data is valid this cycle.
o_c_sof  output  1  word is symbol 0 of a block and carried the SOF mark.
o_c_rs_data_symbol  output  1  valid word with symbol index < RS_K.
o_c_rs_check_symbol  output  1  valid word with symbol index >= RS_K.
o_c_underflow  output  1  sticky: FIFO ran empty mid-block.
o_c_resync_cnt  output  8  saturating count of mid-block SOF resyncs.

Behaviour:
Reset values (i_core_rst=1, synchronous):
- All outputs 0; state IDLE; symbol counter cnt=0.
- Reset mid-block abandons the block with no further outputs.

Threshold:
- thr = max(i_r_half_thres, 1).
- "ready" = (i_c_fifo_level >= thr).

State IDLE:
- No pop.
- Goes to FILL when i_r_enable=1.

State FILL:
- No pop.
- Goes to IDLE when i_r_enable=0.
- Goes to STREAM when ready=1; cnt=0.

State STREAM:
- o_c_fifo_rd_en = ~i_c_fifo_empty.
- On each pop, the next cycle presents: o_c_data=rdata[31:0], o_c_data_valid=1, symbol index idx, o_c_sof=(idx==0 && rdata[32]), data/check tags per idx.
- Latency from pop to output: 1 cycle.

SOF and resync:
- A popped word with rdata[32]=1 while cnt!=0 is a resync.
  - idx forced to 0 for this word.
  - Next cnt=1.
  - o_c_resync_cnt increments, saturating at 255.
- A popped word with rdata[32]=1 while cnt==0 is a normal block start, not a resync.
- Otherwise idx=cnt and cnt increments.

Underflow:
- Empty while in STREAM: no pop, o_c_data_valid=0 with all tags 0, cnt held, o_c_underflow set.
- o_c_underflow clears only on reset.

Block end (pop with idx==RS_N-1):
- cnt wraps to 0.
- Next state: STREAM if i_r_enable && ready, evaluated the same cycle; else FILL if i_r_enable; else IDLE.

i_r_enable deasserted mid-block:
- Has no effect until block end; the block always completes.

Cycles with no pop:
- o_c_data holds its last value; valid and all tags are 0.

Invariant:
- o_c_rs_data_symbol and o_c_rs_check_symbol are mutually exclusive and are never set without o_c_data_valid.

Decomposition:
Shared package rx_cc_pkg holds:
- state enum {IDLE, FILL, STREAM}.
- FIFO word layout constants SOF_BIT=32, DATA_W=32.
- RS_N / RS_K defaults.

Sub-module rx_cc_sym_cnt:
- Contains the symbol counter with wrap, resync-load and the data/check tag decode.
- The FSM and output register stay in rx_cc_rd_ctrl.

Test Plan:
All scenarios use RS_N=8, RS_K=6, ADD_WIDTH=4, thres=4.
1. Fill start: FIFO level 3 -> no pop for 20 cycles. Level goes to 4 -> rd_en next cycle. First output word has SOF bit set -> o_c_sof=1, tagged data.
2. Block tagging: 8 consecutive words D0..D7 with level >=4 throughout -> idx 0..5 data, idx 6..7 check, no gaps. Next block starts back-to-back at idx 0.
3. Underflow: FIFO empty for 3 cycles after idx 3 -> valid=0 for 3 cycles, o_c_underflow=1 stays set. Resume continues at idx 4.
4. Resync: SOF-marked word popped at idx 5 -> output tagged idx 0 with o_c_sof=1; o_c_resync_cnt 0->1; next word idx 1.
5. Drain to FILL and disable: level=2 at block end -> FILL, no pops. Separately, i_r_enable dropped at idx 2 -> idx 3..7 still output, then IDLE.
6. Reset mid-block: i_core_rst pulsed at idx 4 -> next cycle all outputs 0, o_c_resync_cnt=0, state IDLE. Threshold 0: thres=0 with level=1 -> streaming starts.
